// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream helpers: state encodings and byte-enable utilities.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: ST_* state constants, keep_from_cnt() MSB-contiguous mask builder,
//           count_keep() popcount. Functions work on a MAX_BYTES-wide vector so
//           callers of any beat width can size-cast the result down.
package axi_stream_pkg;

    // Widest beat (in bytes) the helpers below can describe.
    localparam int MAX_BYTES = 64;

    // Strip FSM state encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FIRST  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    // ((1<<n)-1) << (bytes-n): n enables packed against the MSB end of a
    // 'bytes'-wide keep vector. Bits at and above 'bytes' are always 0.
    function automatic logic [MAX_BYTES-1:0] keep_from_cnt(input int n, input int bytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if ((i < bytes) && (i >= bytes - n)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Number of set byte enables.
    function automatic logic [7:0] count_keep(input logic [MAX_BYTES-1:0] keep);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            c = c + {7'd0, keep[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/axi_stream_reg_slice.sv
// Single-entry valid/ready output register carrying data/keep/last.
// Latency: one cycle from in handshake to out_vld.
// Backpressure: holds its beat stable while out_vld && !out_rdy; in_rdy = !out_vld || out_rdy.
// Ports: clk/rst (sync, active-high); in_vld/in_rdy/in_dat/in_keep/in_last upstream side;
//        out_vld/out_rdy/out_dat/out_keep/out_last downstream side.
module axi_stream_reg_slice #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [DATA_WD-1:0]      in_dat,
    input  logic [DATA_BYTE_WD-1:0] in_keep,
    input  logic                    in_last,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [DATA_WD-1:0]      out_dat,
    output logic [DATA_BYTE_WD-1:0] out_keep,
    output logic                    out_last
);

    logic                    vld_q,  vld_d;
    logic [DATA_WD-1:0]      dat_q,  dat_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    last_q, last_d;

    // Accept whenever the slot is empty or is being drained this cycle.
    assign in_rdy = !vld_q || out_rdy;

    always_comb begin
        vld_d  = vld_q;
        dat_d  = dat_q;
        keep_d = keep_q;
        last_d = last_q;
        if (in_vld && in_rdy) begin
            vld_d  = 1'b1;
            dat_d  = in_dat;
            keep_d = in_keep;
            last_d = in_last;
        end else if (vld_q && out_rdy) begin
            // Drained with nothing behind it: park the bus at zero.
            vld_d  = 1'b0;
            dat_d  = '0;
            keep_d = '0;
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            keep_q <= keep_d;
            last_q <= last_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_dat  = dat_q;
    assign out_keep = keep_q;
    assign out_last = last_q;

endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes a per-packet command-selected number of leading bytes (1..DATA_BYTE_WD)
// and re-packs the payload MSB-first into full beats.
// Latency: one cycle input handshake -> valid_out; backpressure via registered
// output slice, ready_in = (FIRST|STREAM) && slot free.
// Ports: clk/rst (sync, active-high); valid_in/data_in/keep_in/last_in/ready_in input
//        stream; valid_out/data_out/keep_out/last_out/ready_out output stream;
//        valid_strip/strip_byte_cnt/ready_strip per-packet command; strip_err drop pulse.
module axi_stream_strip_header
    import axi_stream_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  strip_byte_cnt,
    output logic                    ready_strip,
    output logic                    strip_err
);

    // Byte counts (S, H, K, T) need one extra bit so a full beat is representable.
    localparam int CNT_WD = BYTE_CNT_WD + 1;
    localparam int SH_WD  = CNT_WD + 3;

    localparam logic [CNT_WD-1:0] W_CNT = CNT_WD'(DATA_BYTE_WD);

    function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [CNT_WD-1:0] n);
        return DATA_BYTE_WD'(keep_from_cnt(int'(n), DATA_BYTE_WD));
    endfunction

    logic [1:0]         state_q,    state_d;
    logic [CNT_WD-1:0]  s_q,        s_d;         // bytes to strip, 1..W
    logic [DATA_WD-1:0] hold_q,     hold_d;      // carried bytes, MSB-aligned, rest zero
    logic [CNT_WD-1:0]  hold_cnt_q, hold_cnt_d;  // H
    logic               err_q,      err_d;

    logic                    push_vld;
    logic                    sl_rdy;
    logic [DATA_WD-1:0]      push_dat;
    logic [DATA_BYTE_WD-1:0] push_keep;
    logic                    push_last;

    logic [DATA_WD-1:0] mask_in;
    logic [DATA_WD-1:0] data_m;
    logic [CNT_WD-1:0]  k_in;
    logic [CNT_WD-1:0]  t_sum;
    logic [SH_WD-1:0]   s_sh;
    logic [SH_WD-1:0]   h_sh;
    logic [SH_WD-1:0]   rem_sh;
    logic               acc;

    // Zero disabled input bytes so they can never leak into a re-packed beat.
    always_comb begin
        mask_in = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            mask_in[i*8 +: 8] = {8{keep_in[i]}};
        end
    end

    assign data_m = data_in & mask_in;
    assign k_in   = CNT_WD'(count_keep(MAX_BYTES'(keep_in)));
    assign t_sum  = hold_cnt_q + k_in;

    // Byte counts turned into bit shifts (x8).
    assign s_sh   = {s_q, 3'b000};
    assign h_sh   = {hold_cnt_q, 3'b000};
    assign rem_sh = {W_CNT - hold_cnt_q, 3'b000};

    assign ready_strip = (state_q == ST_IDLE);
    assign ready_in    = ((state_q == ST_FIRST) || (state_q == ST_STREAM)) && sl_rdy;
    assign acc         = valid_in && ready_in;
    assign strip_err   = err_q;

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        err_d      = 1'b0;
        push_vld   = 1'b0;
        push_dat   = '0;
        push_keep  = '0;
        push_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid_strip) begin
                    s_d        = {1'b0, strip_byte_cnt} + CNT_WD'(1);
                    hold_d     = '0;
                    hold_cnt_d = '0;
                    state_d    = ST_FIRST;
                end
            end

            ST_FIRST: begin
                if (acc) begin
                    if (!last_in) begin
                        // Full beat: W-S survivors slide to the top. A shift by the
                        // whole width (S=W) leaves an empty hold.
                        hold_d     = data_m << s_sh;
                        hold_cnt_d = k_in - s_q;
                        state_d    = ST_STREAM;
                    end else if (k_in <= s_q) begin
                        // Nothing left after the strip: drop and flag.
                        err_d      = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        push_vld   = 1'b1;
                        push_dat   = data_m << s_sh;
                        push_keep  = keep_of(k_in - s_q);
                        push_last  = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end
                end
            end

            ST_STREAM: begin
                if (acc) begin
                    if (!last_in) begin
                        // H held bytes on top, W-H fresh bytes below; the bottom H
                        // input bytes carry over, so H itself is unchanged.
                        push_vld  = 1'b1;
                        push_dat  = hold_q | (data_m >> h_sh);
                        push_keep = '1;
                        hold_d    = data_m << rem_sh;
                    end else if (t_sum == '0) begin
                        // Empty last beat with nothing held: malformed, emit nothing.
                        hold_d     = '0;
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else if (t_sum <= W_CNT) begin
                        push_vld   = 1'b1;
                        push_dat   = hold_q | (data_m >> h_sh);
                        push_keep  = keep_of(t_sum);
                        push_last  = 1'b1;
                        hold_d     = '0;
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        // Spills past one beat: send a full one, tail goes out in FLUSH.
                        push_vld   = 1'b1;
                        push_dat   = hold_q | (data_m >> h_sh);
                        push_keep  = '1;
                        hold_d     = data_m << rem_sh;
                        hold_cnt_d = t_sum - W_CNT;
                        state_d    = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                if (sl_rdy) begin
                    push_vld   = 1'b1;
                    push_dat   = hold_q;
                    push_keep  = keep_of(hold_cnt_q);
                    push_last  = 1'b1;
                    hold_d     = '0;
                    hold_cnt_d = '0;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            err_q      <= err_d;
        end
    end

    axi_stream_reg_slice #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD)
    ) u_out_slice (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (push_vld),
        .in_rdy   (sl_rdy),
        .in_dat   (push_dat),
        .in_keep  (push_keep),
        .in_last  (push_last),
        .out_vld  (valid_out),
        .out_rdy  (ready_out),
        .out_dat  (data_out),
        .out_keep (keep_out),
        .out_last (last_out)
    );

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: a byte-level model pushes the
// expected output beats per packet; a negedge monitor pops and compares them.
// Backpressure is exercised with a directed stall and random ready_out.
module tb_axi_stream_strip_header;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          last_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          last_out;
    logic          ready_out;
    logic          valid_strip;
    logic [CW-1:0] strip_byte_cnt;
    logic          ready_strip;
    logic          strip_err;

    always #5 clk = ~clk;

    axi_stream_strip_header dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .ready_in       (ready_in),
        .valid_out      (valid_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .ready_out      (ready_out),
        .valid_strip    (valid_strip),
        .strip_byte_cnt (strip_byte_cnt),
        .ready_strip    (ready_strip),
        .strip_err      (strip_err)
    );

    typedef struct packed {
        logic [DW-1:0] dat;
        logic [BW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] pk_q[$];
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         err_exp  = 0;
    int         err_seen = 0;
    bit         rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: drop the first s bytes, chunk the rest into MSB-first beats.
    task automatic model(input int s);
        beat_t b;
        int    j;
        int    n;
        n = pk_q.size();
        if (n - s <= 0) begin
            err_exp++;
            return;
        end
        b = '0;
        j = 0;
        for (int i = s; i < n; i++) begin
            b.dat[DW-1-8*j -: 8] = pk_q[i];
            b.keep[BW-1-j]       = 1'b1;
            j++;
            if (j == BW || i == n - 1) begin
                b.last = (i == n - 1);
                exp_q.push_back(b);
                b = '0;
                j = 0;
            end
        end
    endtask

    task automatic fill_tag(input int n);
        pk_q.delete();
        for (int i = 0; i < n; i++) pk_q.push_back(8'hA0 + 8'((i / 4) * 16 + (i % 4)));
    endtask

    task automatic send_cmd(input int s);
        int t;
        t = 0;
        @(negedge clk);
        while (!ready_strip && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!ready_strip) begin
            check("tmo_cmd", 0, 1);
            return;
        end
        valid_strip    = 1'b1;
        strip_byte_cnt = CW'(s - 1);
        @(posedge clk);
        #1 valid_strip = 1'b0;
    endtask

    task automatic send_beats(input int nmax);
        int n;
        int nb;
        int t;
        n  = pk_q.size();
        nb = (n + BW - 1) / BW;
        for (int b = 0; b < nb && b < nmax; b++) begin
            data_in = '0;
            keep_in = '0;
            for (int j = 0; j < BW; j++) begin
                if (b * BW + j < n) begin
                    data_in[DW-1-8*j -: 8] = pk_q[b*BW+j];
                    keep_in[BW-1-j]        = 1'b1;
                end
            end
            last_in  = (b == nb - 1);
            valid_in = 1'b1;
            t = 0;
            @(negedge clk);
            while (!ready_in && t < 1000) begin
                @(negedge clk);
                t++;
            end
            if (!ready_in) begin
                check("tmo_beat", 0, 1);
                valid_in = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        data_in  = '0;
        keep_in  = '0;
        last_in  = 1'b0;
        if (nmax >= nb) begin
            @(negedge clk);
            check("rdy_in_after_last", 64'(ready_in), 0);
        end
    endtask

    task automatic run_pkt(input int s);
        model(s);
        send_cmd(s);
        send_beats(1000);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    // Output monitor: scoreboard pop, hold-under-stall, strip_err pulse width.
    beat_t         e;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat   = '0;
    logic [BW-1:0] prev_keep  = '0;
    logic          prev_last  = 1'b0;
    logic          prev_err   = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("hold_dat",  64'(data_out), 64'(prev_dat));
                check("hold_keep", 64'(keep_out), 64'(prev_keep));
                check("hold_last", 64'(last_out), 64'(prev_last));
            end
            if (valid_out && !ready_out) check("rdy_in_stall", 64'(ready_in), 0);
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'(data_out), 0);
                    check("extra_beat_vld", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_dat",  64'(data_out), 64'(e.dat));
                    check("out_keep", 64'(keep_out), 64'(e.keep));
                    check("out_last", 64'(last_out), 64'(e.last));
                end
            end
            if (strip_err) begin
                err_seen++;
                if (prev_err) check("err_width", 2, 1);
            end
        end
        prev_stall = !rst && valid_out && !ready_out;
        prev_dat   = data_out;
        prev_keep  = keep_out;
        prev_last  = last_out;
        prev_err   = !rst && strip_err;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) ready_out = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        rst            = 1'b1;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        ready_out      = 1'b1;
        valid_strip    = 1'b0;
        strip_byte_cnt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out",   64'(valid_out),   0);
        check("rst_data_out",    64'(data_out),    0);
        check("rst_keep_out",    64'(keep_out),    0);
        check("rst_last_out",    64'(last_out),    0);
        check("rst_ready_strip", 64'(ready_strip), 1);
        check("rst_ready_in",    64'(ready_in),    0);
        check("rst_strip_err",   64'(strip_err),   0);
        @(posedge clk);
        #1 rst = 1'b0;

        // 1: strip 1, ten bytes -> FLUSH of a single byte.
        fill_tag(10);
        run_pkt(1);
        drain();

        // 2: strip 1, seven bytes -> FLUSH of two bytes.
        fill_tag(7);
        run_pkt(1);
        drain();

        // 3: strip a whole beat, next beat passes straight through.
        fill_tag(8);
        run_pkt(4);
        drain();

        // 4: strip 2 from a two-byte packet -> dropped with strip_err.
        fill_tag(2);
        run_pkt(2);
        check("err_pulse",       64'(strip_err),   1);
        check("err_ready_strip", 64'(ready_strip), 1);
        check("err_no_out",      64'(valid_out),   0);
        @(negedge clk);
        check("err_clear", 64'(strip_err), 0);
        drain();

        // 5: case 1 with ready_out held low 3 cycles after the first output.
        fill_tag(10);
        fork
            run_pkt(1);
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!valid_out && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1 ready_out = 1'b0;
                @(negedge clk);
                check("stall_vld",    64'(valid_out), 1);
                check("stall_rdy_in", 64'(ready_in),  0);
                repeat (2) @(negedge clk);
                @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        drain();

        // 6: reset after the second input beat of case 1.
        fill_tag(10);
        exp_q.push_back(beat_t'({32'hA1A2A3B0, 4'hF, 1'b0}));
        send_cmd(1);
        send_beats(2);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid_out",   64'(valid_out),   0);
        check("mid_rst_ready_strip", 64'(ready_strip), 1);
        check("mid_rst_ready_in",    64'(ready_in),    0);
        check("mid_rst_pending",     64'(exp_q.size()), 0);
        fill_tag(9);
        run_pkt(2);
        drain();

        // Random packets back-to-back under random backpressure.
        rand_rdy = 1'b1;
        for (int p = 0; p < 12; p++) begin
            int s;
            int n;
            s = $urandom_range(1, BW);
            n = $urandom_range(1, 14);
            pk_q.delete();
            for (int i = 0; i < n; i++) pk_q.push_back(8'($urandom_range(1, 255)));
            run_pkt(s);
        end
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 ready_out = 1'b1;
        repeat (3) @(negedge clk);

        check("err_count", 64'(err_seen), 64'(err_exp));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_stream_strip_header.md
Name: axi_stream_strip_header

Overview:
- Downstream companion to the header-insert stage.
- Removes a per-packet, software-selected number of leading bytes (1..DATA_BYTE_WD) from each AXI-Stream packet.
- Re-packs the remaining payload MSB-first into full beats and regenerates keep/last on a registered output.
- Sits between the header-insert output and the packet sink, so the rx path can drop a prepended header.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of strip count field.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- valid_in  input  1  input beat valid
- data_in  input  DATA_WD  input beat; first byte on wire in [DATA_WD-1 -: 8]
- keep_in  input  DATA_BYTE_WD  contiguous-from-MSB byte enables; all ones except on the last beat
- last_in  input  1  last beat of packet
- ready_in  output  1  input ready
- valid_out  output  1  output beat valid
- data_out  output  DATA_WD  output beat; disabled bytes driven 0
- keep_out  output  DATA_BYTE_WD  contiguous-from-MSB byte enables
- last_out  output  1  last beat of output packet
- ready_out  input  1  downstream ready
- valid_strip  input  1  strip command valid
- strip_byte_cnt  input  BYTE_CNT_WD  bytes to remove minus 1 (0 → 1 byte, DATA_BYTE_WD-1 → whole beat)
- ready_strip  output  1  command ready
- strip_err  output  1  one-cycle pulse: packet had ≤ strip bytes and was dropped

Behaviour:
- Reset: state IDLE; ready_strip=1; ready_in=0; valid_out=0; data_out=0; keep_out=0; last_out=0; strip_err=0; hold_cnt=0.

States:
- IDLE
  - ready_strip=1, ready_in=0.
  - On valid_strip: latch S=strip_byte_cnt+1 and go to FIRST.
  - ready_in rises the next cycle; no bypass.
- FIRST
  - Accept beat with K valid bytes.
  - Not last: hold the K-S trailing bytes (0 if S=DATA_BYTE_WD), no output; go to STREAM.
  - Last with K≤S: no output, pulse strip_err, go to IDLE.
  - Last with K>S: emit one beat with K-S bytes and last_out=1; go to IDLE.
- STREAM (hold has H bytes, 0≤H<DATA_BYTE_WD)
  - Non-last beat: output = H held bytes followed by the top W-H bytes of the input, keep all ones. The remaining H input bytes become the new hold.
  - When H=0, the beat passes straight through.
  - Last beat with K bytes, T=H+K:
    - T≤W: emit one beat with T bytes, last_out=1; go to IDLE. If T=0 (H=0, K=0), treat as protocol violation: emit nothing, go to IDLE.
    - T>W: emit a full beat (last_out=0), keep T-W bytes in hold, go to FLUSH.
- FLUSH
  - ready_in=0.
  - Emit hold bytes with keep = top (T-W) bits and last_out=1; go to IDLE after the handshake.

Output register:
- One register slice; latency one cycle from input handshake to valid_out.
- ready_in = state∈{FIRST,STREAM} && (!valid_out || ready_out).
- data_out/keep_out/last_out stay stable while valid_out && !ready_out.
- No combinational path from valid_in to valid_out.

Arithmetic and width rules:
- H and T are held in BYTE_CNT_WD+1 bits.
- keep_out = ((1<<n)-1) << (DATA_BYTE_WD-n).
- Byte shift amounts are multiplied by 8 in a DATA_WD-wide shift.

Boundaries and simultaneous events:
- Back-to-back packets: one IDLE cycle minimum, because a new command is required per packet.
- A command presented while busy waits (ready_strip=0).
- rst mid-packet: all state and outputs return to reset values next edge; the partial packet is discarded and no last_out is produced.

Decomposition:
- Shared package axi_stream_pkg holds:
  - function keep_from_cnt(n), returning the MSB-contiguous mask;
  - function count_keep(keep), a popcount;
  - localparams for state encoding (IDLE, FIRST, STREAM, FLUSH).
- One natural sub-module: axi_stream_reg_slice, a single-entry valid/ready output register carrying data/keep/last.

Test Plan:
- W=32, strip_byte_cnt=0; beats A0A1A2A3/F, B0B1B2B3/F, C0C1C2C3/keep 1100 last → out A1A2A3B0/F, B1B2B3C0/F, C1000000/1000 last.
- strip_byte_cnt=0; A0A1A2A3/F, B0B1B2B3/1110 last → out A1A2A3B0/F, B1B2_0000/1100 last (FLUSH path; ready_in=0 during FLUSH).
- strip_byte_cnt=3; A0A1A2A3/F, B0B1B2B3/F last → single out B0B1B2B3/F last; no other beat.
- strip_byte_cnt=1; single beat A0A1A2A3/1100 last → no valid_out, strip_err high exactly one cycle, ready_strip=1 next cycle.
- Case 1 with ready_out low 3 cycles after first output → data_out/keep_out held, ready_in=0, no byte lost or duplicated.
- rst asserted after the second input beat of case 1 → next cycle valid_out=0, ready_strip=1; a new packet then processes correctly.
